// File: rtl/frag_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frag_pkg : shared constants and types for the fetch stage            |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
package frag_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  localparam int unsigned HOLD_LOAD_USE = 0;
  localparam int unsigned HOLD_EXT      = 1;
  localparam int unsigned HOLD_START    = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } if_state_t;

endpackage
`default_nettype wire

// File: rtl/frag_if_pend_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frag_if_pend_buf : one-entry {pc, instr} buffer for held responses   |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module frag_if_pend_buf
  import frag_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            pop,
  input  logic            clear,
  input  logic [XLEN-1:0] load_pc,
  input  logic [31:0]     load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [31:0]     instr
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    if (clear) begin
      valid_d = 1'b0;
    end else if (load) begin
      valid_d = 1'b1;
      pc_d    = load_pc;
      instr_d = load_instr;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule
`default_nettype wire

// File: rtl/frag_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frag_if_stage : instruction fetch + IF/ID register                   |
// | Optional bubble counter port enabled by FRAG_IF_PERF_EN              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module frag_if_stage
  import frag_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     PC_STEP  = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  input  logic [2:0]      flag_hold,
  input  logic            flag_flush,
  input  logic [XLEN-1:0] jb_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rdata,
  output logic            id_valid,
  output logic [XLEN-1:0] id_pc,
  output logic [31:0]     id_instr
`ifdef FRAG_IF_PERF_EN
  ,
  output logic [31:0]     perf_bubble_cnt
`endif
);

  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  if_state_t       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            id_valid_q, id_valid_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [31:0]     id_instr_q, id_instr_d;

  logic            hold_any, accept, rsp_in_wait;
  logic            pend_load, pend_pop, pend_clear, pend_valid;
  logic [XLEN-1:0] pend_pc;
  logic [31:0]     pend_instr;

  frag_if_pend_buf #(.XLEN(XLEN)) u_pend (
    .clk       (sys_clk),
    .rst       (sys_rst),
    .load      (pend_load),
    .pop       (pend_pop),
    .clear     (pend_clear),
    .load_pc   (req_pc_q),
    .load_instr(imem_rdata),
    .valid     (pend_valid),
    .pc        (pend_pc),
    .instr     (pend_instr)
  );

  always_comb begin
    hold_any       = |flag_hold;
    imem_req_valid = (state_q == FETCH) & ~pend_valid & ~flag_hold[HOLD_START];
    imem_addr      = pc_q;
    accept         = imem_req_valid & imem_req_ready;
    rsp_in_wait    = (state_q == WAIT) & imem_rsp_valid;

    state_d    = state_q;
    pc_d       = pc_q;
    req_pc_d   = req_pc_q;
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_instr_d = id_instr_q;
    pend_load  = 1'b0;
    pend_pop   = 1'b0;
    pend_clear = 1'b0;

    if (accept) begin
      req_pc_d = pc_q;
      pc_d     = pc_q + STEP;
    end

    unique case (state_q)
      IDLE:    if (!flag_hold[HOLD_START]) state_d = FETCH;
      FETCH:   if (accept) state_d = WAIT;
               else if (flag_hold[HOLD_START]) state_d = IDLE;
      WAIT:    if (imem_rsp_valid) state_d = FETCH;
      DROP:    if (imem_rsp_valid) state_d = FETCH;
      default: state_d = IDLE;
    endcase

    if (flag_flush) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
      pend_clear = 1'b1;
      pc_d       = jb_target;
      // A stale response still in flight must be swallowed before refetching;
      // once it has arrived (even in DROP) nothing is outstanding any more.
      unique case (state_q)
        IDLE:    state_d = IDLE;
        FETCH:   state_d = accept ? DROP : FETCH;
        WAIT:    state_d = imem_rsp_valid ? FETCH : DROP;
        DROP:    state_d = imem_rsp_valid ? FETCH : DROP;
        default: state_d = IDLE;
      endcase
    end else if (!hold_any) begin
      if (pend_valid) begin
        id_valid_d = 1'b1;
        id_pc_d    = pend_pc;
        id_instr_d = pend_instr;
        pend_pop   = 1'b1;
      end else if (rsp_in_wait) begin
        id_valid_d = 1'b1;
        id_pc_d    = req_pc_q;
        id_instr_d = imem_rdata;
      end else begin
        id_valid_d = 1'b0;
        id_instr_d = NOP_INSTR;
      end
    end else if (rsp_in_wait) begin
      pend_load = 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_instr_q <= NOP_INSTR;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      req_pc_q   <= req_pc_d;
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_instr_q <= id_instr_d;
    end
  end

  assign id_valid = id_valid_q;
  assign id_pc    = id_pc_q;
  assign id_instr = id_instr_q;

`ifdef FRAG_IF_PERF_EN
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic        bubble_load;

  always_comb begin
    bubble_load  = flag_flush | (~hold_any & ~pend_valid & ~rsp_in_wait);
    bubble_cnt_d = bubble_cnt_q;
    if (!flag_hold[HOLD_START] && bubble_load) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) bubble_cnt_q <= '0;
    else         bubble_cnt_q <= bubble_cnt_d;
  end

  assign perf_bubble_cnt = bubble_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_frag_if_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frag_if_stage : scoreboard bench for the fetch stage              |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
module tb_frag_if_stage;
  import frag_pkg::*;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic [2:0]  flag_hold = 3'b100;
  logic        flag_flush = 1'b0;
  logic [31:0] jb_target = '0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        id_valid;
  logic [31:0] id_pc;
  logic [31:0] id_instr;
`ifdef FRAG_IF_PERF_EN
  logic [31:0] perf_bubble_cnt;
`endif

  frag_if_stage #(.XLEN(32), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .sys_clk        (sys_clk),
    .sys_rst        (sys_rst),
    .flag_hold      (flag_hold),
    .flag_flush     (flag_flush),
    .jb_target      (jb_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_instr       (id_instr)
`ifdef FRAG_IF_PERF_EN
    ,
    .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } id_exp_t;

  logic [31:0] exp_addr_q[$];
  id_exp_t     exp_id_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory model: response word is "addi x1,x0,addr[11:0]".
  int          lat = 1;
  logic        acc_seen = 1'b0;
  logic [31:0] acc_addr = '0;

  initial forever begin
    @(negedge sys_clk);
    acc_seen = imem_req_valid & imem_req_ready;
    acc_addr = imem_addr;
  end

  initial begin
    int          cd;
    bit          busy;
    logic [31:0] paddr;
    cd = 0; busy = 0; paddr = '0;
    forever begin
      @(posedge sys_clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (acc_seen) begin
        busy  = 1;
        cd    = lat;
        paddr = acc_addr;
      end
      if (busy) begin
        cd--;
        if (cd == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rdata     = {paddr[11:0], 20'h00093};
          busy           = 0;
        end
      end
    end
  end

  // Monitor: every accepted request and every instruction decode consumes.
  initial forever begin
    @(negedge sys_clk);
    if (imem_req_valid && imem_req_ready) begin
      if (exp_addr_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_req: addr %h, none expected", imem_addr);
      end else begin
        check("req_addr", imem_addr, exp_addr_q.pop_front());
      end
    end
    if (id_valid && !sys_rst && flag_hold == 3'b000 && !flag_flush) begin
      if (exp_id_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL unexpected_id: pc %h instr %h, none expected", id_pc, id_instr);
      end else begin
        id_exp_t e;
        e = exp_id_q.pop_front();
        check("id_pc", id_pc, e.pc);
        check("id_instr", id_instr, e.instr);
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #2;
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (imem_rsp_valid) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s: timeout got no response expected one", name);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge sys_clk);
      if (imem_req_valid) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s: timeout got no request expected one", name);
  endtask

  task automatic wait_idv(input string name);
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge sys_clk);
      if (id_valid) return;
    end
    n_checks++; n_fail++;
    $display("FAIL %s: timeout got no id_valid expected one", name);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_valid"}, imem_req_valid, 32'd0);
    check({tag, "_id_valid"}, id_valid, 32'd0);
    check({tag, "_id_pc"}, id_pc, 32'd0);
    check({tag, "_id_instr"}, id_instr, 32'h0000_0013);
`ifdef FRAG_IF_PERF_EN
    check({tag, "_perf"}, perf_bubble_cnt, 32'd0);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          bad;
    logic [31:0] c1, c2;

    // 1: reset, core not started
    repeat (2) tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_state("reset");
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge sys_clk);
      if (imem_req_valid || id_valid || id_instr !== 32'h0000_0013) bad++;
    end
    check("idle_quiet_cycles", bad, 32'd0);

    // 2: start with 1-cycle memory
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_addr_q.push_back(32'hC);
    exp_id_q.push_back('{32'h0, 32'h0000_0093});
    exp_id_q.push_back('{32'h4, 32'h0040_0093});
    exp_id_q.push_back('{32'h8, 32'h0080_0093});
    tick();
    flag_hold = 3'b000;
    wait_rsp("rsp0");
    wait_rsp("rsp4");
    wait_rsp("rsp8");

    // 3: load-use hold while the response for 8 arrives
    flag_hold = 3'b001;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge sys_clk);
      check("hold_no_req", imem_req_valid, 32'd0);
      check("hold_id_unchanged", id_valid, 32'd0);
    end
    tick();
    flag_hold = 3'b000;
    @(negedge sys_clk);
    check("release_buffer_first", imem_req_valid, 32'd0);
    tick();
    lat = 3;
    @(negedge sys_clk);
    check("release_id_valid", id_valid, 32'd1);
    check("release_id_pc", id_pc, 32'h8);
    check("resume_req_valid", imem_req_valid, 32'd1);

    // 4: flush while waiting on a 3-cycle response
    exp_addr_q.push_back(32'h100);
    tick();
    flag_flush = 1'b1;
    jb_target  = 32'h100;
    tick();
    flag_flush = 1'b0;
    @(negedge sys_clk);
    check("flush_id_valid", id_valid, 32'd0);
    check("drop_no_req", imem_req_valid, 32'd0);
    wait_req("req_after_drop");
    check("redirect_addr", imem_addr, 32'h100);

    // 5: flush and external hold together with a buffered response
    exp_addr_q.push_back(32'h200);
    exp_addr_q.push_back(32'h204);
    exp_id_q.push_back('{32'h200, 32'h2000_0093});
    wait_rsp("rsp100");
    flag_hold = 3'b010;
    tick();
    flag_flush = 1'b1;
    jb_target  = 32'h200;
    @(negedge sys_clk);
    check("held_buffer_no_req", imem_req_valid, 32'd0);
    tick();
    flag_flush = 1'b0;
    flag_hold  = 3'b000;
    @(negedge sys_clk);
    check("flush_hold_req", imem_req_valid, 32'd1);
    check("flush_hold_pc", imem_addr, 32'h200);
    check("flush_hold_id_valid", id_valid, 32'd0);
    wait_rsp("rsp200");
    tick();
    @(negedge sys_clk);
    check("target_id_valid", id_valid, 32'd1);
    check("target_id_instr", id_instr, 32'h2000_0093);

    // 6: reset while waiting; the late response must be ignored
    tick();
    sys_rst   = 1'b1;
    flag_hold = 3'b100;
    tick();
    sys_rst = 1'b0;
    @(negedge sys_clk);
    check_reset_state("midwait_reset");
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      @(negedge sys_clk);
      if (imem_req_valid || id_valid || id_pc !== 32'h0) bad++;
    end
    check("late_rsp_ignored", bad, 32'd0);

    // restart from RESET_PC with 3-cycle memory
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_id_q.push_back('{32'h0, 32'h0000_0093});
    exp_id_q.push_back('{32'h4, 32'h0040_0093});
    tick();
    flag_hold = 3'b000;
    wait_idv("restart_id0");
    c1 = id_pc;
    check("restart_first_pc", c1, 32'h0);
`ifdef FRAG_IF_PERF_EN
    c1 = perf_bubble_cnt;
    check("perf_first", c1, 32'd4);
`endif
    wait_idv("restart_id4");
`ifdef FRAG_IF_PERF_EN
    c2 = perf_bubble_cnt;
    check("perf_per_instr", c2 - c1, 32'd3);
`else
    c2 = id_pc;
    check("restart_second_pc", c2, 32'h4);
`endif
    tick();
    check("addr_queue_drained", exp_addr_q.size(), 32'd0);
    check("id_queue_drained", exp_id_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
